// File: rtl/bomb_drop_sched.sv
// Mad-bomber drop scheduler: walks the bomber to random LFSR-chosen columns on frame
// ticks and hands each bomb to the sprite engine over a valid/ready handshake.
module bomb_drop_sched #(
  parameter int X_MIN      = 64,
  parameter int COL_W      = 16,
  parameter int X_RESET    = 312,
  parameter int WAVE_BOMBS = 16,
  parameter int DROP_GAP   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       frame_tick,
  input  logic [1:0] level,
  input  logic [4:0] rand_data,
  input  logic       rand_bit,
  input  logic       bomb_ready,
  output logic       bomb_valid,
  output logic [9:0] bomb_x,
  output logic [9:0] bomber_x,
  output logic [5:0] bombs_left,
  output logic       busy,
  output logic       wave_done
);

  typedef enum logic [2:0] {IDLE, PICK, MOVE, DROP, GAP} state_t;

  state_t     state_r, state_s;
  logic [9:0] target_r, target_s;
  logic [7:0] gap_r, gap_s;
  logic [9:0] bomber_x_s, bomb_x_s;
  logic       bomb_valid_s, busy_s, wave_done_s;
  logic [5:0] bombs_left_s;
  logic [9:0] step_s, dist_s;
  logic [7:0] gap_base_s, gap_sub_s;

  // Next-state and next-output logic; abort overrides everything outside IDLE.
  always_comb begin
    state_s      = state_r;
    target_s     = target_r;
    gap_s        = gap_r;
    bomber_x_s   = bomber_x;
    bomb_x_s     = bomb_x;
    bomb_valid_s = bomb_valid;
    bombs_left_s = bombs_left;
    wave_done_s  = 1'b0;
    step_s       = {8'd0, level} + 10'd1;
    dist_s       = (target_r >= bomber_x) ? (target_r - bomber_x) : (bomber_x - target_r);
    gap_base_s   = 8'(DROP_GAP) + {7'd0, rand_bit};
    gap_sub_s    = {5'd0, level, 1'b0};

    case (state_r)
      IDLE: begin
        if (start) begin
          bombs_left_s = 6'(WAVE_BOMBS);
          state_s      = PICK;
        end else begin
          state_s = IDLE;
        end
      end
      PICK: begin
        target_s = 10'(X_MIN) + 10'(rand_data) * 10'(COL_W);
        state_s  = MOVE;
      end
      MOVE: begin
        if (frame_tick) begin
          if (dist_s <= step_s) begin
            bomber_x_s = target_r;
            state_s    = DROP;
          end else if (target_r > bomber_x) begin
            bomber_x_s = bomber_x + step_s;
          end else begin
            bomber_x_s = bomber_x - step_s;
          end
        end else begin
          state_s = MOVE;
        end
      end
      DROP: begin
        // First DROP cycle registers the bomb; ticks are ignored so the bomber freezes.
        if (!bomb_valid) begin
          bomb_valid_s = 1'b1;
          bomb_x_s     = bomber_x;
        end else if (bomb_ready) begin
          bomb_valid_s = 1'b0;
          bombs_left_s = bombs_left - 6'd1;
          if (bombs_left == 6'd1) begin
            wave_done_s = 1'b1;
            state_s     = IDLE;
          end else begin
            gap_s   = (gap_base_s > gap_sub_s) ? (gap_base_s - gap_sub_s) : 8'd1;
            state_s = GAP;
          end
        end else begin
          state_s = DROP;
        end
      end
      GAP: begin
        if (frame_tick) begin
          if (gap_r <= 8'd1) begin
            gap_s   = 8'd0;
            state_s = PICK;
          end else begin
            gap_s = gap_r - 8'd1;
          end
        end else begin
          state_s = GAP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (abort && (state_r != IDLE)) begin
      state_s      = IDLE;
      bomb_valid_s = 1'b0;
      bombs_left_s = 6'd0;
      wave_done_s  = 1'b0;
      gap_s        = 8'd0;
    end else begin
      state_s = state_s;
    end

    busy_s = (state_s != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      target_r   <= 10'(X_RESET);
      gap_r      <= 8'd0;
      bomber_x   <= 10'(X_RESET);
      bomb_x     <= 10'd0;
      bomb_valid <= 1'b0;
      bombs_left <= 6'd0;
      busy       <= 1'b0;
      wave_done  <= 1'b0;
    end else begin
      state_r    <= state_s;
      target_r   <= target_s;
      gap_r      <= gap_s;
      bomber_x   <= bomber_x_s;
      bomb_x     <= bomb_x_s;
      bomb_valid <= bomb_valid_s;
      bombs_left <= bombs_left_s;
      busy       <= busy_s;
      wave_done  <= wave_done_s;
    end
  end

endmodule

// File: tb/tb_bomb_drop_sched.sv
// Scoreboard bench for bomb_drop_sched: expected drop positions are queued by the
// stimulus and consumed by a handshake monitor; state checks are directed.
module tb_bomb_drop_sched;
  logic       clk = 1'b0;
  logic       rst, start, abort, frame_tick, rand_bit, bomb_ready;
  logic [1:0] level;
  logic [4:0] rand_data;
  logic       bomb_valid, busy, wave_done;
  logic [9:0] bomb_x, bomber_x;
  logic [5:0] bombs_left;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int wd_cnt   = 0;
  logic [9:0] exp_q[$];

  bomb_drop_sched dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_tick(frame_tick),
    .level(level), .rand_data(rand_data), .rand_bit(rand_bit), .bomb_ready(bomb_ready),
    .bomb_valid(bomb_valid), .bomb_x(bomb_x), .bomber_x(bomber_x),
    .bombs_left(bombs_left), .busy(busy), .wave_done(wave_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
  endtask

  task automatic run_to_drop(input int budget);
    int n = 0;
    while (!bomb_valid && n < budget) begin
      tick();
      n++;
    end
    check("drop_reached", 32'(bomb_valid), 32'd1);
  endtask

  // Handshake monitor: every real acceptance must match the oldest queued drop position.
  always @(negedge clk) begin
    if (rst && bomb_valid && bomb_ready && !abort) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_bomb: got x=%0d expected none", bomb_x);
      end else begin
        check("bomb_x_accept", 32'(bomb_x), 32'(exp_q.pop_front()));
      end
    end
    if (rst && wave_done) wd_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic stable;
    int   d, tgt, prev, expx;
    rst = 1'b0; start = 1'b0; abort = 1'b0; frame_tick = 1'b0;
    level = 2'd3; rand_data = 5'd0; rand_bit = 1'b0; bomb_ready = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    check("rst_bomber_x", 32'(bomber_x), 32'd312);
    check("rst_bomb_x", 32'(bomb_x), 32'd0);
    check("rst_valid", 32'(bomb_valid), 32'd0);
    check("rst_bombs_left", 32'(bombs_left), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // T1: async reset in the middle of a move
    pulse_start();
    ticks(3);
    check("t1_move_x", 32'(bomber_x), 32'd300);
    rst = 1'b0;
    #1;
    check("t1_async_x", 32'(bomber_x), 32'd312);
    check("t1_async_valid", 32'(bomb_valid), 32'd0);
    check("t1_async_busy", 32'(busy), 32'd0);
    check("t1_async_left", 32'(bombs_left), 32'd0);
    cyc(2);
    rst = 1'b1;
    cyc(1);

    // T2: column 0 at level 3 -> 62 ticks of 4 px
    pulse_start();
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_left", 32'(bombs_left), 32'd16);
    ticks(61);
    check("t2_x_61", 32'(bomber_x), 32'd68);
    check("t2_no_valid_yet", 32'(bomb_valid), 32'd0);
    exp_q.push_back(10'd64);
    tick();
    check("t2_valid", 32'(bomb_valid), 32'd1);
    check("t2_bomb_x", 32'(bomb_x), 32'd64);

    // T3: renderer stall with frame ticks, then accept
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      frame_tick = (c % 6 == 2);
      cyc(1);
      if (bomb_valid !== 1'b1 || bomb_x !== 10'd64 || bomber_x !== 10'd64) stable = 1'b0;
    end
    frame_tick = 1'b0;
    check("t3_stall_stable", 32'(stable), 32'd1);
    bomb_ready = 1'b1;
    cyc(1);
    bomb_ready = 1'b0;
    check("t3_left_15", 32'(bombs_left), 32'd15);
    check("t3_valid_drop", 32'(bomb_valid), 32'd0);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check("t3_abort_busy", 32'(busy), 32'd0);
    check("t3_abort_left", 32'(bombs_left), 32'd0);

    // T4: full wave at level 0 with jitter bit set; gap must be exactly 9 ticks
    level = 2'd0; rand_bit = 1'b1; bomb_ready = 1'b1;
    rand_data = 5'd20;
    prev = 384;
    exp_q.push_back(10'd384);
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      run_to_drop(400);
      cyc(1);
      if (i < 15) begin
        d = 20 + ((i + 1) % 2);
        tgt = 64 + 16 * d;
        exp_q.push_back(10'(tgt));
        rand_data = 5'(d);
        expx = (tgt > prev) ? prev + 1 : prev - 1;
        ticks(10);
        check("t4_gap9_step", 32'(bomber_x), 32'(expx));
        prev = tgt;
      end else begin
        check("t4_wave_done", 32'(wave_done), 32'd1);
        check("t4_busy_off", 32'(busy), 32'd0);
        check("t4_left_0", 32'(bombs_left), 32'd0);
      end
    end
    cyc(1);
    check("t4_done_pulse", 32'(wave_done), 32'd0);
    check("t4_done_count", 32'(wd_cnt), 32'd1);

    // T5: abort in the same cycle as the 5th accept
    level = 2'd2; rand_bit = 1'b0; rand_data = 5'd21;
    repeat (4) exp_q.push_back(10'd400);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      run_to_drop(20);
      cyc(1);
    end
    run_to_drop(20);
    check("t5_left_12", 32'(bombs_left), 32'd12);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_left", 32'(bombs_left), 32'd0);
    check("t5_valid", 32'(bomb_valid), 32'd0);
    check("t5_no_done", 32'(wave_done), 32'd0);
    cyc(2);
    check("t5_done_count", 32'(wd_cnt), 32'd1);

    // T6: rightmost column and a start pulse while busy
    level = 2'd3; rand_data = 5'd31; bomb_ready = 1'b0;
    exp_q.push_back(10'd560);
    pulse_start();
    ticks(20);
    check("t6_x_20", 32'(bomber_x), 32'd480);
    pulse_start();
    check("t6_start_ignored", 32'(bombs_left), 32'd16);
    check("t6_busy", 32'(busy), 32'd1);
    ticks(19);
    check("t6_x_39", 32'(bomber_x), 32'd556);
    run_to_drop(5);
    check("t6_bomber_x", 32'(bomber_x), 32'd560);
    check("t6_bomb_x", 32'(bomb_x), 32'd560);
    bomb_ready = 1'b1;
    cyc(1);
    bomb_ready = 1'b0;
    check("t6_left_15", 32'(bombs_left), 32'd15);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    cyc(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_done_count", 32'(wd_cnt), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
